parallel_to_serial: RTL and testbench
=====================================

Name: parallel_to_serial

Overview:
- Transmit-side counterpart of the team's serial-to-parallel receive control.
- Accepts one wide word of N_SAMPLES packed samples on a val/rdy input port and replays it one sample per handshake on a narrow val/rdy output port.
- Sits between parallel producers (e.g. FFT output) and serial consumers (SPI/stream adapters).
- Contains both the control FSM and the capture register/mux datapath.

Parameters:
- BIT_WIDTH, 32, width of one sample.
- N_SAMPLES, 8, samples per parallel word; must be >= 2. Counter width is CW = $clog2(N_SAMPLES).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- recv_msg  input  BIT_WIDTH*N_SAMPLES  parallel word; sample i occupies bits [i*BIT_WIDTH +: BIT_WIDTH]
- recv_val  input  1  recv_msg valid
- recv_rdy  output  1  block can capture a word
- send_msg  output  BIT_WIDTH  current serial sample
- send_val  output  1  send_msg valid
- send_rdy  input  1  downstream accepts send_msg

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - Asserting reset immediately forces state=IDLE, count=0 and capture register=0, with no clock edge needed.
  - While reset is high: recv_rdy=0, send_val=0, send_msg=0.
  - On the first clock edge after reset deasserts, recv_rdy=1.
- States: IDLE, SEND. Registered state; outputs are decoded combinationally from state/count only, never from recv_val or send_rdy.
- IDLE:
  - recv_rdy=1, send_val=0, send_msg=0.
  - If recv_val=1 at the clock edge: capture recv_msg, set count=0, go to SEND.
  - Otherwise hold.
- SEND:
  - recv_rdy=0, send_val=1, send_msg = captured sample[count].
  - Sample 0 (LSBs) is sent first.
  - On an edge with send_rdy=1 (fire) and count<N_SAMPLES-1: count increments.
  - On a fire with count=N_SAMPLES-1: count resets to 0 and state returns to IDLE.
  - With send_rdy=0: count, state and send_msg hold stable. send_val must not drop until the sample is accepted.
- Latency and throughput:
  - send_val rises in the cycle after the recv handshake.
  - One sample per cycle while send_rdy=1.
  - Minimum N_SAMPLES+1 cycles per parallel word (one capture bubble).
  - recv_rdy is low throughout SEND.
- Boundaries:
  - recv_msg changes or recv_val pulses during SEND are ignored; the captured word is immutable until IDLE.
  - A recv_val already high when entering IDLE is captured on the next edge.
  - count never exceeds N_SAMPLES-1. Any out-of-range count is unreachable; if reached, treat it as the last sample.
  - Reset asserted mid-SEND aborts the word. No partial resume; the remaining samples are discarded.

Test Plan:
- Reset then idle: hold reset 3 cycles, release with recv_val=0 -> recv_rdy=0 during reset, 1 after; send_val=0 and send_msg=0 throughout.
- Basic burst (BIT_WIDTH=8, N_SAMPLES=4): recv_msg=0x44332211, recv_val=1 for one cycle, send_rdy=1 -> next 4 cycles send_msg=0x11,0x22,0x33,0x44 with send_val=1; recv_rdy=1 on the 5th cycle.
- Backpressure: same word, send_rdy toggling 1,0,0,1,1,0,1 -> each sample held stable while stalled; exactly 4 fires, in order, with no duplicates.
- Back-to-back words: recv_val held high with 0x44332211 then 0xDDCCBBAA -> 8 samples 0x11..0x44, 0xAA..0xDD; one idle cycle between words with send_val=0.
- Input ignored during SEND: change recv_msg to 0xFFFFFFFF and pulse recv_val mid-burst -> output sequence unchanged; recv_rdy stays 0.
- Async reset mid-burst: assert reset between edges after the 2nd sample -> send_val drops immediately without a clock edge; after release, a new word 0x08070605 serialises from 0x05.

Source files
------------

// File: rtl/parallel_to_serial.sv
// -----------------------------------------------------------------------------
// parallel_to_serial
//   Captures one wide word of N_SAMPLES packed samples from a val/rdy input port
//   and replays it one sample per handshake on a narrow val/rdy output port.
//   Sample 0 (the LSBs) goes out first. While a word is being sent the input
//   port is closed, so the captured word cannot change mid-burst.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   recv_msg  in   parallel word, sample i at [i*BIT_WIDTH +: BIT_WIDTH]
//   recv_val  in   recv_msg valid
//   recv_rdy  out  block can capture a word (IDLE only)
//   send_msg  out  current serial sample (0 when not sending)
//   send_val  out  send_msg valid (SEND only)
//   send_rdy  in   downstream accepts send_msg
// -----------------------------------------------------------------------------
module parallel_to_serial #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int CW = $clog2(N_SAMPLES);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [BIT_WIDTH*N_SAMPLES-1:0] data_q, data_d;
  // Output enable: stays low through reset and rises on the first clock edge
  // after reset is released, so recv_rdy is held low until the block has seen
  // a clean edge.
  logic                           out_en_q, out_en_d;

  // Clamped sample index: any out-of-range count is treated as the last sample.
  logic [CW-1:0]                  sel_idx;

  // Next-state, counter and capture-register logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    out_en_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (recv_val && out_en_q) begin
          data_d  = recv_msg;
          count_d = {CW{1'b0}};
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (send_rdy) begin
          // ">=" so an unreachable out-of-range count still ends the word.
          if (count_q >= LAST_IDX) begin
            count_d = {CW{1'b0}};
            state_d = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
  end

  // State, counter, capture register and output-enable flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      data_q   <= {(BIT_WIDTH*N_SAMPLES){1'b0}};
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      out_en_q <= out_en_d;
    end
  end

  // Output decode from registered state/count only.
  always_comb begin
    sel_idx  = count_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = {BIT_WIDTH{1'b0}};
    if (count_q > LAST_IDX) begin
      sel_idx = LAST_IDX;
    end else begin
      sel_idx = count_q;
    end
    case (state_q)
      IDLE: begin
        recv_rdy = out_en_q;
        send_val = 1'b0;
        send_msg = {BIT_WIDTH{1'b0}};
      end
      SEND: begin
        recv_rdy = 1'b0;
        send_val = 1'b1;
        send_msg = data_q[sel_idx*BIT_WIDTH +: BIT_WIDTH];
      end
      default: begin
        recv_rdy = 1'b0;
        send_val = 1'b0;
        send_msg = {BIT_WIDTH{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// -----------------------------------------------------------------------------
// tb_parallel_to_serial
//   Directed bench for parallel_to_serial with BIT_WIDTH=8, N_SAMPLES=4.
//   Inputs are driven 1 ns after the rising edge; outputs are checked in the
//   same window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_parallel_to_serial;

  localparam int BW = 8;
  localparam int NS = 4;

  logic          clk;
  logic          reset;
  logic [BW*NS-1:0] recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy;

  int n_checks;
  int n_pass;

  parallel_to_serial #(
    .BIT_WIDTH (BW),
    .N_SAMPLES (NS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect one SEND cycle showing the given sample.
  task automatic expect_send(input string tag, input logic [7:0] exp);
    check({tag, "_val"}, {31'd0, send_val}, 32'd1);
    check({tag, "_msg"}, {24'd0, send_msg}, {24'd0, exp});
    check({tag, "_rdy"}, {31'd0, recv_rdy}, 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_val"}, {31'd0, send_val}, 32'd0);
    check({tag, "_msg"}, {24'd0, send_msg}, 32'd0);
    check({tag, "_rdy"}, {31'd0, recv_rdy}, 32'd1);
  endtask

  logic [7:0] pat_rdy [7];
  logic [BW*NS-1:0] word;
  int idx;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    recv_msg = 32'h0;
    recv_val = 1'b0;
    send_rdy = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rdy", {31'd0, recv_rdy}, 32'd0);
      check("rst_val", {31'd0, send_val}, 32'd0);
      check("rst_msg", {24'd0, send_msg}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rel_rdy_pre_edge", {31'd0, recv_rdy}, 32'd0);
    tick();
    expect_idle("rel_idle");

    // Basic burst.
    recv_msg = 32'h44332211;
    recv_val = 1'b1;
    send_rdy = 1'b1;
    tick();
    recv_val = 1'b0;
    expect_send("b0", 8'h11); tick();
    expect_send("b1", 8'h22); tick();
    expect_send("b2", 8'h33); tick();
    expect_send("b3", 8'h44); tick();
    expect_idle("b_end");

    // Backpressure: send_rdy pattern 1,0,0,1,1,0,1 gives exactly 4 fires.
    pat_rdy[0] = 8'd1; pat_rdy[1] = 8'd0; pat_rdy[2] = 8'd0; pat_rdy[3] = 8'd1;
    pat_rdy[4] = 8'd1; pat_rdy[5] = 8'd0; pat_rdy[6] = 8'd1;
    word     = 32'h44332211;
    recv_msg = word;
    recv_val = 1'b1;
    send_rdy = 1'b0;
    tick();
    recv_val = 1'b0;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      send_rdy = pat_rdy[i][0];
      expect_send("bp", word[idx*BW +: BW]);
      tick();
      if (pat_rdy[i][0]) idx = idx + 1;
    end
    send_rdy = 1'b1;
    check("bp_fires", idx, 32'd4);
    expect_idle("bp_end");

    // Back-to-back words with recv_val held high.
    recv_msg = 32'h44332211;
    recv_val = 1'b1;
    send_rdy = 1'b1;
    tick();
    recv_msg = 32'hDDCCBBAA;
    expect_send("bb0", 8'h11); tick();
    expect_send("bb1", 8'h22); tick();
    expect_send("bb2", 8'h33); tick();
    expect_send("bb3", 8'h44); tick();
    expect_idle("bb_gap");
    tick();
    recv_val = 1'b0;
    expect_send("bb4", 8'hAA); tick();
    expect_send("bb5", 8'hBB); tick();
    expect_send("bb6", 8'hCC); tick();
    expect_send("bb7", 8'hDD); tick();
    expect_idle("bb_end");

    // Input changes and recv_val pulse during SEND are ignored.
    recv_msg = 32'h44332211;
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    expect_send("ig0", 8'h11);
    recv_msg = 32'hFFFFFFFF;
    recv_val = 1'b1;
    tick();
    expect_send("ig1", 8'h22);
    recv_val = 1'b0;
    tick();
    expect_send("ig2", 8'h33); tick();
    expect_send("ig3", 8'h44); tick();
    expect_idle("ig_end");

    // Async reset mid-burst, then a fresh word.
    recv_msg = 32'h44332211;
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    expect_send("ar0", 8'h11); tick();
    expect_send("ar1", 8'h22);
    #2;
    reset = 1'b1;
    #1;
    check("ar_val_drop", {31'd0, send_val}, 32'd0);
    check("ar_msg_zero", {24'd0, send_msg}, 32'd0);
    check("ar_rdy_low",  {31'd0, recv_rdy}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("ar_rel_rdy", {31'd0, recv_rdy}, 32'd0);
    tick();
    expect_idle("ar_idle");
    recv_msg = 32'h08070605;
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    expect_send("ar2", 8'h05); tick();
    expect_send("ar3", 8'h06); tick();
    expect_send("ar4", 8'h07); tick();
    expect_send("ar5", 8'h08); tick();
    expect_idle("ar_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
